// File: rtl/pc_gen_pkg.sv
// pc_gen_pkg: shared constants and types for the fetch-stage PC generator.
//   state_e      : BOOT (ROM disabled, waiting out reset) / RUN (fetching)
//   RST_ENABLE   : active level of the synchronous reset
//   CHIP_ENABLE / CHIP_DISABLE : instruction ROM enable levels
//   STOP         : stall_i level that holds the PC
//   BRANCH       : branch_flag_i level for a taken branch
package pc_gen_pkg;

  typedef enum logic {
    BOOT = 1'b0,
    RUN  = 1'b1
  } state_e;

  localparam logic RST_ENABLE   = 1'b1;
  localparam logic CHIP_ENABLE  = 1'b1;
  localparam logic CHIP_DISABLE = 1'b0;
  localparam logic STOP         = 1'b1;
  localparam logic BRANCH       = 1'b1;

endpackage

// File: rtl/pc_pend_latch.sv
// pc_pend_latch: holds a branch target that resolved while fetch was stalled.
//   clk, rst   : clock, synchronous active-high reset
//   set        : capture addr_in (a newer capture overwrites an older one)
//   clr        : drop the pending entry
//   addr_in    : branch target to capture
//   pend_addr  : captured target
//   pend_valid : a captured target is waiting
module pc_pend_latch
  import pc_gen_pkg::*;
#(
  parameter int ADDR_W = 32
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              set,
  input  logic              clr,
  input  logic [ADDR_W-1:0] addr_in,
  output logic [ADDR_W-1:0] pend_addr,
  output logic              pend_valid
);

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      pend_addr  <= '0;
      pend_valid <= 1'b0;
    end else if (set) begin
      pend_addr  <= addr_in;
      pend_valid <= 1'b1;
    end else if (clr) begin
      pend_valid <= 1'b0;
    end
  end

endmodule

// File: rtl/pc_gen.sv
// pc_gen: program-counter generator for the in-order fetch stage.
//   clk, rst       : clock, synchronous active-high reset
//   stall_i        : hold the PC
//   branch_flag_i  : branch taken, target on branch_addr_i
//   flush_i        : exception/eret redirect to new_pc_i (beats stall)
//   pc             : registered fetch address
//   ce             : registered instruction ROM enable
//   pend_valid_o   : a branch seen during a stall is waiting
//   misalign_o     : registered, pc has nonzero alignment bits
//
// state | meaning
// BOOT  | in or just out of reset, ROM disabled, pc = RESET_VECTOR
// RUN   | fetching, ce = 1
module pc_gen
  import pc_gen_pkg::*;
#(
  parameter int              ADDR_W       = 32,
  parameter logic [ADDR_W-1:0] RESET_VECTOR = '0,
  parameter int              INST_BYTES   = 4,
  parameter int              ALIGN_BITS   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              stall_i,
  input  logic              branch_flag_i,
  input  logic [ADDR_W-1:0] branch_addr_i,
  input  logic              flush_i,
  input  logic [ADDR_W-1:0] new_pc_i,
  output logic [ADDR_W-1:0] pc,
  output logic              ce,
  output logic              pend_valid_o,
  output logic              misalign_o
);

  state_e            state_q, state_d;
  logic [ADDR_W-1:0] pc_d;
  logic [ADDR_W-1:0] pend_addr;
  logic              pend_set, pend_clr;
  logic              mis_d;

  always_ff @(posedge clk) begin
    if (rst == RST_ENABLE) begin
      state_q    <= BOOT;
      pc         <= RESET_VECTOR;
      misalign_o <= 1'b0;
    end else begin
      state_q    <= state_d;
      pc         <= pc_d;
      misalign_o <= mis_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    pc_d     = pc;
    pend_set = 1'b0;
    pend_clr = 1'b0;
    unique case (state_q)
      BOOT: begin
        // First fetch is the reset vector itself, not its successor.
        state_d = RUN;
        pc_d    = RESET_VECTOR;
      end
      RUN: begin
        if (flush_i) begin
          pc_d     = new_pc_i;
          pend_clr = 1'b1;
        end else if (stall_i == STOP) begin
          pend_set = (branch_flag_i == BRANCH);
        end else if (pend_valid_o) begin
          // A fresh branch is younger than the latched one and wins.
          pc_d     = (branch_flag_i == BRANCH) ? branch_addr_i : pend_addr;
          pend_clr = 1'b1;
        end else if (branch_flag_i == BRANCH) begin
          pc_d = branch_addr_i;
        end else begin
          pc_d = pc + ADDR_W'(INST_BYTES);
        end
      end
      default: state_d = BOOT;
    endcase
  end

  generate
    if (ALIGN_BITS > 0) begin : g_align
      assign mis_d = |pc_d[ALIGN_BITS-1:0];
    end else begin : g_no_align
      assign mis_d = 1'b0;
    end
  endgenerate

  assign ce = (state_q == RUN) ? CHIP_ENABLE : CHIP_DISABLE;

  pc_pend_latch #(
    .ADDR_W(ADDR_W)
  ) u_pend (
    .clk       (clk),
    .rst       (rst),
    .set       (pend_set),
    .clr       (pend_clr),
    .addr_in   (branch_addr_i),
    .pend_addr (pend_addr),
    .pend_valid(pend_valid_o)
  );

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed scoreboard bench for pc_gen. Two instances share all
// stimulus: dut_a uses reset vector 0, dut_b uses 0xBFC00000.
module tb_pc_gen;

  typedef struct packed {
    logic [31:0] pc_a;
    logic [31:0] pc_b;
    logic        ce;
    logic        pend;
    logic        mis;
  } exp_t;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        stall_i = 1'b0;
  logic        branch_flag_i = 1'b0;
  logic [31:0] branch_addr_i = '0;
  logic        flush_i = 1'b0;
  logic [31:0] new_pc_i = '0;

  logic [31:0] pc_a, pc_b;
  logic        ce_a, ce_b, pend_a, pend_b, mis_a, mis_b;

  exp_t exp_q[$];
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  pc_gen #(.ADDR_W(32), .RESET_VECTOR(32'h0000_0000)) dut_a (
    .clk(clk), .rst(rst), .stall_i(stall_i), .branch_flag_i(branch_flag_i),
    .branch_addr_i(branch_addr_i), .flush_i(flush_i), .new_pc_i(new_pc_i),
    .pc(pc_a), .ce(ce_a), .pend_valid_o(pend_a), .misalign_o(mis_a)
  );

  pc_gen #(.ADDR_W(32), .RESET_VECTOR(32'hBFC0_0000)) dut_b (
    .clk(clk), .rst(rst), .stall_i(stall_i), .branch_flag_i(branch_flag_i),
    .branch_addr_i(branch_addr_i), .flush_i(flush_i), .new_pc_i(new_pc_i),
    .pc(pc_b), .ce(ce_b), .pend_valid_o(pend_b), .misalign_o(mis_b)
  );

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    checks++;
    if (got !== want) begin
      errors++;
      $display("FAIL %s @%0t: got %h expected %h", name, $time, got, want);
    end
  endtask

  // Monitor: outputs are valid every cycle, so one expectation per edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (exp_q.size() > 0) begin
        e = exp_q.pop_front();
        chk("pc_a",   pc_a,          e.pc_a);
        chk("ce_a",   32'(ce_a),     32'(e.ce));
        chk("pend_a", 32'(pend_a),   32'(e.pend));
        chk("mis_a",  32'(mis_a),    32'(e.mis));
        chk("pc_b",   pc_b,          e.pc_b);
        chk("ce_b",   32'(ce_b),     32'(e.ce));
        chk("pend_b", 32'(pend_b),   32'(e.pend));
        chk("mis_b",  32'(mis_b),    32'(e.mis));
      end
    end
  end

  // Drive one cycle of inputs at the falling edge and queue what the
  // outputs must be after the following rising edge.
  task automatic step(input logic r, input logic st, input logic br,
                      input logic [31:0] ba, input logic fl, input logic [31:0] np,
                      input logic [31:0] epa, input logic [31:0] epb,
                      input logic ece, input logic epend, input logic emis);
    exp_t e;
    @(negedge clk);
    rst = r; stall_i = st; branch_flag_i = br; branch_addr_i = ba;
    flush_i = fl; new_pc_i = np;
    e.pc_a = epa; e.pc_b = epb; e.ce = ece; e.pend = epend; e.mis = emis;
    exp_q.push_back(e);
  endtask

  task automatic idle(input logic [31:0] epa, input logic [31:0] epb,
                      input logic emis);
    step(0, 0, 0, 0, 0, 0, epa, epb, 1, 0, emis);
  endtask

  localparam logic [31:0] RB = 32'hBFC0_0000;

  initial begin
    // Reset held three cycles, then release and count up.
    for (int i = 0; i < 3; i++)
      step(1, 0, 0, 0, 0, 0, 32'h0, RB, 0, 0, 0);
    step(0, 0, 0, 0, 0, 0, 32'h0, RB, 1, 0, 0);
    idle(32'h4,  RB + 32'h4,  0);
    idle(32'h8,  RB + 32'h8,  0);
    idle(32'hC,  RB + 32'hC,  0);
    idle(32'h10, RB + 32'h10, 0);

    // Branch to the top of the address space and wrap.
    step(0, 0, 1, 32'hFFFF_FFFC, 0, 0, 32'hFFFF_FFFC, 32'hFFFF_FFFC, 1, 0, 0);
    idle(32'h0, 32'h0, 0);
    step(0, 0, 1, 32'h20, 0, 0, 32'h20, 32'h20, 1, 0, 0);

    // Stall three cycles, branch resolved in the second.
    step(0, 1, 0, 0,          0, 0, 32'h20, 32'h20, 1, 0, 0);
    step(0, 1, 1, 32'h100,    0, 0, 32'h20, 32'h20, 1, 1, 0);
    step(0, 1, 0, 0,          0, 0, 32'h20, 32'h20, 1, 1, 0);
    idle(32'h100, 32'h100, 0);
    idle(32'h104, 32'h104, 0);

    // Newer branch during a stall overwrites the older one.
    step(0, 1, 1, 32'h300, 0, 0, 32'h104, 32'h104, 1, 1, 0);
    step(0, 1, 1, 32'h400, 0, 0, 32'h104, 32'h104, 1, 1, 0);
    idle(32'h400, 32'h400, 0);

    // Branch arriving with the release beats the pending target.
    step(0, 1, 1, 32'h500, 0, 0, 32'h400, 32'h400, 1, 1, 0);
    step(0, 0, 1, 32'h600, 0, 0, 32'h600, 32'h600, 1, 0, 0);
    idle(32'h604, 32'h604, 0);

    // Flush overrides stall and discards the pending branch.
    step(0, 1, 1, 32'h700, 0, 0,       32'h604, 32'h604, 1, 1, 0);
    step(0, 1, 0, 0,       1, 32'h180, 32'h180, 32'h180, 1, 0, 0);
    idle(32'h184, 32'h184, 0);
    // Flush beats a simultaneous branch.
    step(0, 0, 1, 32'h900, 1, 32'h200, 32'h200, 32'h200, 1, 0, 0);

    // Misaligned target loads and flags; flush clears the flag.
    step(0, 0, 1, 32'h202, 0, 0,       32'h202, 32'h202, 1, 0, 1);
    idle(32'h206, 32'h206, 1);
    step(0, 0, 0, 0,       1, 32'h180, 32'h180, 32'h180, 1, 0, 0);

    // Reset with a branch pending mid-stall.
    step(0, 0, 1, 32'h40,  0, 0, 32'h40, 32'h40, 1, 0, 0);
    step(0, 1, 1, 32'h800, 0, 0, 32'h40, 32'h40, 1, 1, 0);
    step(1, 1, 0, 0,       0, 0, 32'h0,  RB,     0, 0, 0);
    step(1, 0, 0, 0,       0, 0, 32'h0,  RB,     0, 0, 0);
    // BOOT ignores branch, flush and stall on the release edge.
    step(0, 1, 1, 32'h900, 1, 32'h999, 32'h0, RB, 1, 0, 0);
    idle(32'h4, RB + 32'h4, 0);

    @(negedge clk);
    stall_i = 0; branch_flag_i = 0; flush_i = 0;
    repeat (3) @(posedge clk);
    #2;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d pending expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
